// File: rtl/iterative_divider_64.sv
// iterative_divider_64: radix-2 restoring UDIV/SDIV, one quotient bit per cycle.
module iterative_divider_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r, q, d, mag_a, mag_b;
  logic [WIDTH:0] shifted, trial;
  logic neg_q, neg_r, div0, sa, sb, zero_div;
  assign sa = is_signed & dividend[WIDTH-1];
  assign sb = is_signed & divisor[WIDTH-1];
  assign mag_a = sa ? -dividend : dividend;
  assign mag_b = sb ? -divisor : divisor;
  assign zero_div = divisor == '0;
  // partial remainder keeps its carry-out bit so divisors >= 2^(WIDTH-1) still divide correctly
  assign shifted = {r, q[WIDTH-1]};
  assign trial = shifted - {1'b0, d};
  assign busy = state == RUN || state == FIX;
  assign done = state == DONE;
  always_comb begin
    state_next = state == IDLE ? (start ? (zero_div ? FIX : RUN) : IDLE) :
                 state == RUN  ? (cnt == CW'(WIDTH - 1) ? FIX : RUN) :
                 state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // on divide-by-zero q carries the raw dividend through to the remainder
          r <= '0;
          q <= zero_div ? dividend : mag_a;
          d <= mag_b;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          div0 <= zero_div;
          cnt <= '0;
        end
        RUN: begin
          r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          quotient <= div0 ? '0 : neg_q ? -q : q;
          remainder <= div0 ? q : neg_r ? -r : r;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_divider_64.sv
// tb_iterative_divider_64: scoreboard bench for latency, handshake, reset and arithmetic.
module tb_iterative_divider_64;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [63:0] dividend = '0, divisor = '0;
  logic busy, done;
  logic [63:0] quotient, remainder;
  int n_checks = 0, n_pass = 0;
  typedef struct {logic [63:0] q; logic [63:0] r;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [63:0] last_q = '0, last_r = '0;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  iterative_divider_64 dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic void ref_div(input logic s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r);
    if (b == '0) begin q = '0; r = a; end
    else if (!s) begin q = a / b; r = a % b; end
    else if (b == '1) begin q = -a; r = '0; end
    else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
  endfunction

  always @(negedge clock) if (done) begin
    if (sb.size() == 0) check_eq("spurious_done", 64'(done), 64'd0);
    else begin
      e = sb.pop_front();
      check_eq("quotient", quotient, e.q);
      check_eq("remainder", remainder, e.r);
    end
  end

  task automatic do_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er,
                       input int lat, input int rep, input bit start_in_done);
    int k;
    @(negedge clock);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("hold_q", quotient, last_q);
    check_eq("hold_r", remainder, last_r);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    sb.push_back('{eq, er});
    k = 0;
    do begin
      @(negedge clock);
      k++;
      start = (k == rep);
      is_signed = ~s;
      dividend = {$urandom, $urandom};
      divisor = (k == rep) ? 64'd3 : {$urandom, $urandom};
      if (!done) check_eq("busy", 64'(busy), 64'd1);
    end while (!done && k < 80);
    check_eq("latency", 64'(k), 64'(lat));
    check_eq("done_busy", 64'(busy), 64'd0);
    last_q = eq; last_r = er;
    if (start_in_done) begin start = 1'b1; is_signed = 1'b0; dividend = 64'd999; divisor = 64'd1; end
    else start = 1'b0;
  endtask

  initial begin
    logic [63:0] a, b, q, r;
    logic s;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_q", quotient, 64'd0);
    check_eq("rst_r", remainder, 64'd0);
    reset = 1'b0;
    do_op(0, 64'd562, 64'd196, 64'd2, 64'd170, 66, 0, 0);
    do_op(1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, '1, 66, 0, 0);
    do_op(1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 0, 0);
    do_op(0, 64'h1234, 64'd0, 64'd0, 64'h1234, 2, 0, 0);
    do_op(1, 64'h1234, 64'd0, 64'd0, 64'h1234, 2, 0, 0);
    do_op(1, MIN, '1, MIN, 64'd0, 66, 0, 0);
    do_op(0, '1, 64'd1, '1, 64'd0, 66, 0, 0);
    do_op(0, 64'd1000, 64'd7, 64'd142, 64'd6, 66, 10, 0);
    do_op(0, 64'd50, 64'd8, 64'd6, 64'd2, 66, 0, 1);
    do_op(1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0);
    @(negedge clock);
    is_signed = 1'b0; dividend = 64'd123456; divisor = 64'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (28) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_q", quotient, 64'd0);
    check_eq("mid_rst_r", remainder, 64'd0);
    reset = 1'b0;
    last_q = '0; last_r = '0;
    repeat (80) @(negedge clock);
    do_op(0, 64'd100, 64'd7, 64'd14, 64'd2, 66, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      s = i[0];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i % 7 == 3) a = a >> $urandom_range(0, 63);
      ref_div(s, a, b, q, r);
      do_op(s, a, b, q, r, (b == '0) ? 2 : 66, 0, 0);
    end
    @(negedge clock);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
